// File: rtl/register_rename_if.sv
// register_rename_if: decode/wakeup/free-list inputs and renamed-source outputs of the rename stage.
interface register_rename_if;
    logic        wakeup_0_active, wakeup_1_active, wakeup_2_active, wakeup_3_active;
    logic [5:0]  wakeup_0_tag, wakeup_1_tag, wakeup_2_tag, wakeup_3_tag;
    logic [31:0] wakeup_0_value, wakeup_1_value, wakeup_2_value, wakeup_3_value;
    logic [5:0]  freed_tag_1, freed_tag_2;
    logic [4:0]  architectural_rd, architectural_rs1, architectural_rs2;
    logic [5:0]  physical_rd, physical_rs1, physical_rs2;
    logic        rs1_ready, rs2_ready;
    logic [31:0] rs1_value, rs2_value;

    modport master (
        output wakeup_0_active, wakeup_1_active, wakeup_2_active, wakeup_3_active,
               wakeup_0_tag, wakeup_1_tag, wakeup_2_tag, wakeup_3_tag,
               wakeup_0_value, wakeup_1_value, wakeup_2_value, wakeup_3_value,
               freed_tag_1, freed_tag_2,
               architectural_rd, architectural_rs1, architectural_rs2,
        input  physical_rd, physical_rs1, physical_rs2,
               rs1_ready, rs2_ready, rs1_value, rs2_value
    );

    modport slave (
        input  wakeup_0_active, wakeup_1_active, wakeup_2_active, wakeup_3_active,
               wakeup_0_tag, wakeup_1_tag, wakeup_2_tag, wakeup_3_tag,
               wakeup_0_value, wakeup_1_value, wakeup_2_value, wakeup_3_value,
               freed_tag_1, freed_tag_2,
               architectural_rd, architectural_rs1, architectural_rs2,
        output physical_rd, physical_rs1, physical_rs2,
               rs1_ready, rs2_ready, rs1_value, rs2_value
    );
endinterface

// File: rtl/register_rename.sv
// register_rename: RAT + circular free list + physical register file with four wakeup ports and bypass.
module register_rename (
    input  logic clk,
    input  logic reset,
    register_rename_if.slave rr
);
    logic [5:0]  rat [32];
    logic [31:0] prf [64];
    logic [63:0] rdy;
    logic [5:0]  fl [64];
    logic [5:0]  head, tail;
    logic [6:0]  count;
    logic [3:0]  wa;
    logic [5:0]  wt [4];
    logic [31:0] wv [4];
    logic        alloc, push1, push2;
    logic [5:0]  ps1, ps2;
    logic        r1, r2;
    logic [31:0] v1, v2;

    assign wa = {rr.wakeup_3_active, rr.wakeup_2_active, rr.wakeup_1_active, rr.wakeup_0_active};
    assign wt[0] = rr.wakeup_0_tag;
    assign wt[1] = rr.wakeup_1_tag;
    assign wt[2] = rr.wakeup_2_tag;
    assign wt[3] = rr.wakeup_3_tag;
    assign wv[0] = rr.wakeup_0_value;
    assign wv[1] = rr.wakeup_1_value;
    assign wv[2] = rr.wakeup_2_value;
    assign wv[3] = rr.wakeup_3_value;

    assign alloc = rr.architectural_rd != 5'd0 && count != 7'd0;
    // Fullness is judged on the pre-pop count, with the first push counted against the second.
    assign push1 = rr.freed_tag_1 != 6'd0 && count < 7'd64;
    assign push2 = rr.freed_tag_2 != 6'd0 && count + 7'(push1) < 7'd64;

    always_comb begin
        ps1 = rat[rr.architectural_rs1];
        ps2 = rat[rr.architectural_rs2];
        r1 = rdy[ps1];
        v1 = prf[ps1];
        r2 = rdy[ps2];
        v2 = prf[ps2];
        // Descending scan so the lowest-numbered matching port is the last to assign.
        for (int p = 3; p >= 0; p--) begin
            if (wa[p] && wt[p] == ps1 && ps1 != 6'd0) begin
                r1 = 1'b1;
                v1 = wv[p];
            end
            if (wa[p] && wt[p] == ps2 && ps2 != 6'd0) begin
                r2 = 1'b1;
                v2 = wv[p];
            end
        end
    end

    assign rr.physical_rs1 = ps1;
    assign rr.physical_rs2 = ps2;
    assign rr.rs1_ready = r1;
    assign rr.rs2_ready = r2;
    assign rr.rs1_value = v1;
    assign rr.rs2_value = v2;
    assign rr.physical_rd = alloc ? fl[head] : 6'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rat[i] <= 6'(i);
            for (int i = 0; i < 64; i++) begin
                prf[i] <= '0;
                fl[i] <= 6'(i + 32);
            end
            rdy <= '1;
            head <= 6'd0;
            tail <= 6'd32;
            count <= 7'd32;
        end else begin
            for (int p = 3; p >= 0; p--) begin
                if (wa[p] && wt[p] != 6'd0) begin
                    prf[wt[p]] <= wv[p];
                    rdy[wt[p]] <= 1'b1;
                end
            end
            // Allocation is written after the wakeups so it overrides a same-edge wakeup to the new tag.
            if (alloc) begin
                rat[rr.architectural_rd] <= fl[head];
                prf[fl[head]] <= '0;
                rdy[fl[head]] <= 1'b0;
                head <= head + 6'd1;
            end
            if (push1) fl[tail] <= rr.freed_tag_1;
            if (push2) fl[tail + 6'(push1)] <= rr.freed_tag_2;
            tail <= tail + 6'(push1) + 6'(push2);
            count <= count + 7'(push1) + 7'(push2) - 7'(alloc);
        end
    end
endmodule

// File: tb/tb_register_rename.sv
// tb_register_rename: directed scenarios plus randomized traffic against a queue/array reference model.
module tb_register_rename;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    register_rename_if bus();
    register_rename dut (.clk(clk), .reset(reset), .rr(bus));

    int checks = 0;
    int failures = 0;

    logic [5:0]  rat_m [32];
    logic [31:0] val_m [64];
    logic        rdy_m [64];
    logic [5:0]  free_q [$];

    logic        wa [4];
    logic [5:0]  wt [4];
    logic [31:0] wv [4];
    logic [5:0]  f1, f2;
    logic [4:0]  rd, rs1, rs2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) rat_m[i] = 6'(i);
        for (int i = 0; i < 64; i++) begin
            val_m[i] = 0;
            rdy_m[i] = 1'b1;
        end
        free_q = {};
        for (int i = 32; i < 64; i++) free_q.push_back(6'(i));
    endtask

    task automatic idle();
        for (int p = 0; p < 4; p++) begin
            wa[p] = 1'b0;
            wt[p] = 0;
            wv[p] = 0;
        end
        f1 = 0;
        f2 = 0;
        rd = 0;
        rs1 = 0;
        rs2 = 0;
    endtask

    task automatic drive();
        bus.wakeup_0_active = wa[0]; bus.wakeup_0_tag = wt[0]; bus.wakeup_0_value = wv[0];
        bus.wakeup_1_active = wa[1]; bus.wakeup_1_tag = wt[1]; bus.wakeup_1_value = wv[1];
        bus.wakeup_2_active = wa[2]; bus.wakeup_2_tag = wt[2]; bus.wakeup_2_value = wv[2];
        bus.wakeup_3_active = wa[3]; bus.wakeup_3_tag = wt[3]; bus.wakeup_3_value = wv[3];
        bus.freed_tag_1 = f1;
        bus.freed_tag_2 = f2;
        bus.architectural_rd = rd;
        bus.architectural_rs1 = rs1;
        bus.architectural_rs2 = rs2;
    endtask

    task automatic src_exp(input logic [4:0] rs, output logic [5:0] t, output logic r, output logic [31:0] v);
        bit found = 0;
        t = rat_m[rs];
        r = rdy_m[t];
        v = val_m[t];
        for (int p = 0; p < 4; p++) begin
            if (!found && wa[p] && wt[p] == t && t != 0) begin
                found = 1;
                r = 1'b1;
                v = wv[p];
            end
        end
    endtask

    task automatic apply();
        logic [5:0] t1, t2;
        logic r1, r2;
        logic [31:0] v1, v2;
        drive();
        #1;
        src_exp(rs1, t1, r1, v1);
        src_exp(rs2, t2, r2, v2);
        chk("physical_rs1", 32'(bus.physical_rs1), 32'(t1));
        chk("physical_rs2", 32'(bus.physical_rs2), 32'(t2));
        chk("rs1_ready", 32'(bus.rs1_ready), 32'(r1));
        chk("rs2_ready", 32'(bus.rs2_ready), 32'(r2));
        chk("rs1_value", bus.rs1_value, v1);
        chk("rs2_value", bus.rs2_value, v2);
        chk("physical_rd", 32'(bus.physical_rd), (rd != 0 && free_q.size() > 0) ? 32'(free_q[0]) : 32'd0);
    endtask

    task automatic step();
        int sz;
        bit p1;
        logic [5:0] t;
        logic [63:0] seen;
        @(posedge clk);
        sz = free_q.size();
        seen = '0;
        for (int p = 0; p < 4; p++) begin
            if (wa[p] && wt[p] != 0 && !seen[wt[p]]) begin
                seen[wt[p]] = 1'b1;
                val_m[wt[p]] = wv[p];
                rdy_m[wt[p]] = 1'b1;
            end
        end
        if (rd != 0 && sz > 0) begin
            t = free_q.pop_front();
            rat_m[rd] = t;
            rdy_m[t] = 1'b0;
            val_m[t] = 0;
        end
        p1 = f1 != 0 && sz < 64;
        if (p1) free_q.push_back(f1);
        if (f2 != 0 && sz + int'(p1) < 64) free_q.push_back(f2);
        @(negedge clk);
    endtask

    initial begin
        idle();
        drive();
        model_reset();
        #12 reset = 1'b1;
        @(negedge clk);

        rd = 1; rs1 = 0; rs2 = 1;
        apply();
        chk("t1_prd", 32'(bus.physical_rd), 32'd32);
        chk("t1_prs2", 32'(bus.physical_rs2), 32'd1);
        chk("t1_rdy", 32'({bus.rs1_ready, bus.rs2_ready}), 32'd3);
        chk("t1_val", bus.rs1_value | bus.rs2_value, 32'd0);
        step();

        apply();
        chk("t2_prs2", 32'(bus.physical_rs2), 32'd32);
        chk("t2_prd", 32'(bus.physical_rd), 32'd33);
        chk("t2_rs2_ready", 32'(bus.rs2_ready), 32'd0);
        chk("t2_rs1_ready", 32'(bus.rs1_ready), 32'd1);
        step();

        rd = 0; wa[0] = 1; wt[0] = 32; wv[0] = 123;
        apply();
        chk("t3_prs2", 32'(bus.physical_rs2), 32'd33);
        chk("t3_rs2_ready", 32'(bus.rs2_ready), 32'd0);
        chk("t3_prd", 32'(bus.physical_rd), 32'd0);
        step();

        wt[0] = 33; wv[0] = 456;
        apply();
        chk("t4_rs2_ready", 32'(bus.rs2_ready), 32'd1);
        chk("t4_rs2_value", bus.rs2_value, 32'd456);
        step();

        wa[0] = 0;
        apply();
        chk("t5_rs2_ready", 32'(bus.rs2_ready), 32'd1);
        chk("t5_rs2_value", bus.rs2_value, 32'd456);
        chk("t5_prs2", 32'(bus.physical_rs2), 32'd33);
        step();

        for (int n = 0; n < 40 && free_q.size() > 0; n++) begin
            rd = 5'($urandom_range(31, 1));
            rs1 = 5'($urandom);
            rs2 = 5'($urandom);
            apply();
            step();
        end
        chk("t6_empty", 32'(free_q.size()), 32'd0);
        rd = 7; rs1 = 7;
        apply();
        chk("t6_prd_empty", 32'(bus.physical_rd), 32'd0);
        step();
        rd = 0; f1 = 40;
        apply();
        step();
        f1 = 0; rd = 3;
        apply();
        chk("t6_prd_40", 32'(bus.physical_rd), 32'd40);
        step();

        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 4; p++) begin
                wa[p] = 1'($urandom);
                wt[p] = ($urandom_range(3, 0) == 0) ? rat_m[5'($urandom)] : 6'($urandom);
                wv[p] = $urandom;
            end
            f1 = ($urandom_range(1, 0) == 0) ? 6'd0 : 6'($urandom);
            f2 = ($urandom_range(2, 0) == 0) ? 6'($urandom) : 6'd0;
            rd = ($urandom_range(3, 0) == 0) ? 5'd0 : 5'($urandom);
            rs1 = 5'($urandom);
            rs2 = ($urandom_range(3, 0) == 0) ? rs1 : 5'($urandom);
            apply();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
